alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's combinational add/sub ALU.
- Adds logic ops, signed compare, iterative shifts (one bit per cycle) and an optional iterative shift-add multiplier.
- Uses a start/busy/done handshake so the control unit can stall on multi-cycle ops.
- Keeps the existing zero/pos flag convention: each flag is a full datapath word holding 0 or 1, so flags feed branch logic unchanged.

Parameters:
- WIDTH, 16: datapath width of in0, in1, out, zero and pos.
- SHAMT_W, 4: shift-amount bits taken from in1; equals log2(WIDTH).
- MUL_EN, 1: 1 enables the MUL op; 0 removes the multiplier and treats MUL as an invalid op.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op  input  4  operation code, sampled at accept.
- in0  input  WIDTH  operand A, sampled at accept.
- in1  input  WIDTH  operand B / shift amount, sampled at accept.
- busy  output  1  high while a multi-cycle op iterates.
- done  output  1  one-cycle pulse when out and flags update.
- out  output  WIDTH  registered result; holds until the next done.
- zero  output  WIDTH  1 if result == 0, else 0.
- pos  output  WIDTH  1 if result != 0 and MSB == 0, else 0.
- carry  output  1  ADD: carry out. SUB: 1 = no borrow. Otherwise 0.
- ovf  output  1  signed overflow for ADD/SUB; otherwise 0.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 MUL: low WIDTH bits of the unsigned product.
  - 9 SLT: out = 1 if signed in0 < signed in1, else 0.
  - 10-15 invalid: out = 0, zero = 1, carry = ovf = 0, single-cycle.
- Reset (async, any state): FSM goes to IDLE; out, zero, pos, carry, ovf, busy, done and all internal registers clear to 0.
- FSM states: IDLE, SHIFT, MUL, FIN.
- IDLE:
  - start = 1 accepts the request and latches op, in0, in1. Call this edge cycle 0.
  - Single-cycle ops (0-4, 9, invalid, and shifts with shamt = 0) compute combinationally and go directly to FIN.
  - SHIFT/MUL entry: shamt = in1[SHAMT_W-1:0]. A shift with shamt != 0 enters SHIFT with counter = shamt. MUL (MUL_EN = 1) enters MUL with counter = WIDTH, accumulator = 0, multiplicand = in0, multiplier = in1.
- SHIFT:
  - Each cycle shifts the working value by 1: SLL fills 0, SRL fills 0, SRA replicates the MSB.
  - Counter decrements each cycle; at 1 the next state is FIN.
  - busy = 1 for exactly shamt cycles.
- MUL:
  - Each cycle: if multiplier[0] = 1, accumulator += multiplicand (mod 2^WIDTH). Then multiplicand <<= 1 and multiplier >>= 1.
  - Runs WIDTH cycles; busy = 1 throughout. No early termination.
- FIN (one cycle): registers out, zero, pos, carry and ovf; done = 1; returns to IDLE.
- Latency from accept edge to done high:
  - single-cycle ops: 1 cycle.
  - shift: shamt + 1 cycles.
  - MUL: WIDTH + 1 cycles.
- A new start is accepted in the cycle after done, so there is one idle cycle minimum between ops.
- start while not IDLE (SHIFT, MUL, FIN) is ignored and not queued. Operand/op changes after accept have no effect.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum; carry = sum[WIDTH]. SUB computes in0 + ~in1 + 1.
  - ovf: ADD sets it when the operand signs match and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from in0.
- Flags are computed from the final result only. zero and pos are never both 1; both are 0 for negative results.

Test Plan:
- WIDTH = 16. ADD 0x7FFF + 0x0001 -> done at cycle 1, out = 0x8000, ovf = 1, carry = 0, zero = 0, pos = 0. Then ADD 0xFFFF + 0x0001 -> out = 0x0000, carry = 1, zero = 0x0001.
- SUB 5 - 5 -> out = 0, zero = 0x0001, pos = 0, carry = 1. SUB 3 - 5 -> out = 0xFFFE, carry = 0, zero = pos = 0. SLT 0xFFFE vs 0x0001 -> out = 1, pos = 0x0001.
- SRA 0x8000 by 3 -> busy high cycles 1-3, done at cycle 4, out = 0xF000. SRL same operands -> 0x1000. SLL 0x0001 by 0 -> done at cycle 1, out = 0x0001.
- MUL 300 x 200 -> busy for 16 cycles, done at cycle 17, out = 0xEA60, pos = 0. A start pulse with ADD at cycle 5 is ignored: out stays 0xEA60, exactly one done pulse.
- Reset asserted mid-MUL (cycle 8, asynchronous, between edges) -> all outputs 0 immediately. The next accepted ADD 2 + 2 gives out = 4, pos = 0x0001 at cycle 1.
- MUL_EN = 0 build: op 8 -> done at cycle 1, out = 0, zero = 0x0001. Op 12 behaves the same in either build.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with one-bit-per-cycle shifts and a shift-add multiplier.
// Ports: clk, reset (async, active-high), start/op/in0/in1 request,
//        busy/done handshake, out, zero/pos word flags, carry, ovf.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int MUL_EN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] zero,
    output logic [WIDTH-1:0] pos,
    output logic             carry,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             v_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             is_shift;
    logic             is_mul;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] shifted;

    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign is_mul   = (MUL_EN != 0) && (op == OP_MUL);
    assign shamt    = CNT_W'(in1[SHAMT_W-1:0]);

    // Single-cycle results, computed straight from the request operands.
    always_comb begin
        sum    = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, in0} + {1'b0, in1};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (in0[WIDTH-1] == in1[WIDTH-1]) &&
                         (sum[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, in0} + {1'b0, ~in1} + 1'b1;
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (in0[WIDTH-1] != in1[WIDTH-1]) &&
                         (sum[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_AND: sc_res = in0 & in1;
            OP_OR:  sc_res = in0 | in1;
            OP_XOR: sc_res = in0 ^ in1;
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}},
                              $signed(in0) < $signed(in1)};
            default: sc_res = '0;
        endcase
    end

    // One-bit step of the latched shift op.
    always_comb begin
        shifted = res_q;
        case (op_q)
            OP_SLL:  shifted = {res_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, res_q[WIDTH-1:1]};
            OP_SRA:  shifted = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
            default: shifted = res_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            res_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            zero     <= '0;
            pos      <= '0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        c_q  <= 1'b0;
                        v_q  <= 1'b0;
                        if (is_shift) begin
                            res_q <= in0;
                            cnt_q <= shamt;
                            state <= (shamt == '0) ? S_FIN : S_SHIFT;
                        end else if (is_mul) begin
                            res_q    <= '0;
                            mcand_q  <= in0;
                            mplier_q <= in1;
                            cnt_q    <= CNT_W'(WIDTH);
                            state    <= S_MUL;
                        end else begin
                            res_q <= sc_res;
                            c_q   <= sc_c;
                            v_q   <= sc_v;
                            state <= S_FIN;
                        end
                    end
                end
                S_SHIFT: begin
                    busy  <= 1'b1;
                    res_q <= shifted;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state <= S_FIN;
                end
                S_MUL: begin
                    busy <= 1'b1;
                    if (mplier_q[0])
                        res_q <= res_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state <= S_FIN;
                end
                default: begin
                    out   <= res_q;
                    zero  <= {{(WIDTH-1){1'b0}}, res_q == '0};
                    pos   <= {{(WIDTH-1){1'b0}},
                              (res_q != '0) && !res_q[WIDTH-1]};
                    carry <= c_q;
                    ovf   <= v_q;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, random ops against an arithmetic model,
// and hand sequences for ignored start, async reset and MUL_EN=0.
module tb_alu_seq;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e_out;
        logic        e_zero;
        logic        e_pos;
        logic        e_carry;
        logic        e_ovf;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_n = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] in0 = '0;
    logic [15:0] in1 = '0;
    logic        busy, done, carry, ovf;
    logic [15:0] out, zero, pos;
    logic        busy_n, done_n, carry_n, ovf_n;
    logic [15:0] out_n, zero_n, pos_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16), .SHAMT_W(4), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .in0(in0), .in1(in1), .busy(busy), .done(done),
        .out(out), .zero(zero), .pos(pos),
        .carry(carry), .ovf(ovf)
    );

    alu_seq #(.WIDTH(16), .SHAMT_W(4), .MUL_EN(0)) dut_n (
        .clk(clk), .reset(reset), .start(start_n), .op(op),
        .in0(in0), .in1(in1), .busy(busy_n), .done(done_n),
        .out(out_n), .zero(zero_n), .pos(pos_n),
        .carry(carry_n), .ovf(ovf_n)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [3:0] o,
                                   input logic [15:0] a,
                                   input logic [15:0] b,
                                   input bit mul_en);
        vec_t v;
        int unsigned ua, ub, r;
        int sa, sb, sr, sh;
        logic signed [15:0] t;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        sh = int'(b[3:0]);
        v.op = o; v.a = a; v.b = b;
        v.e_out = '0; v.e_carry = 0; v.e_ovf = 0; v.lat = 1;
        case (o)
            4'd0: begin
                r = ua + ub; v.e_out = r[15:0]; v.e_carry = r[16];
                sr = sa + sb; v.e_ovf = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                r = ua - ub; v.e_out = r[15:0]; v.e_carry = ua >= ub;
                sr = sa - sb; v.e_ovf = (sr > 32767) || (sr < -32768);
            end
            4'd2: v.e_out = a & b;
            4'd3: v.e_out = a | b;
            4'd4: v.e_out = a ^ b;
            4'd5: begin v.e_out = a << sh; v.lat = sh + 1; end
            4'd6: begin v.e_out = a >> sh; v.lat = sh + 1; end
            4'd7: begin
                t = a; t = t >>> sh; v.e_out = t; v.lat = sh + 1;
            end
            4'd8: if (mul_en) begin
                r = ua * ub; v.e_out = r[15:0]; v.lat = 17;
            end
            4'd9: v.e_out = {15'd0, sa < sb};
            default: v.e_out = '0;
        endcase
        v.e_zero = v.e_out == 16'd0;
        v.e_pos  = (v.e_out != 16'd0) && !v.e_out[15];
        return v;
    endfunction

    task automatic run_op(input string tag, input vec_t v);
        int k, nb;
        bit got;
        @(negedge clk);
        start = 1'b1; op = v.op; in0 = v.a; in1 = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'($urandom); in0 = 16'($urandom); in1 = 16'($urandom);
        nb = 0; got = 0; k = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (busy) nb++;
            if (done) begin got = 1; k = i; end
        end
        if (!got) k = 99;
        chk({tag, ".lat"}, k, v.lat);
        chk({tag, ".busy"}, nb, v.lat - 1);
        chk({tag, ".out"}, out, v.e_out);
        chk({tag, ".zero"}, zero, {15'd0, v.e_zero});
        chk({tag, ".pos"}, pos, {15'd0, v.e_pos});
        chk({tag, ".carry"}, carry, v.e_carry);
        chk({tag, ".ovf"}, ovf, v.e_ovf);
    endtask

    task automatic run_nm(input string tag, input logic [3:0] o);
        int k;
        bit got;
        @(negedge clk);
        start_n = 1'b1; op = o; in0 = 16'd300; in1 = 16'd200;
        @(posedge clk);
        #1;
        start_n = 1'b0;
        got = 0; k = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done_n) begin got = 1; k = i; end
        end
        if (!got) k = 99;
        chk({tag, ".lat"}, k, 1);
        chk({tag, ".out"}, out_n, 16'd0);
        chk({tag, ".zero"}, zero_n, 16'd1);
        chk({tag, ".pos"}, pos_n, 16'd0);
    endtask

    vec_t tbl[$];
    vec_t rv;
    int   nd, dk;

    initial begin
        tbl.push_back('{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, 1, 1});
        tbl.push_back('{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, 1});
        tbl.push_back('{4'd1, 16'h0005, 16'h0005, 16'h0000, 1, 0, 1, 0, 1});
        tbl.push_back('{4'd1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0, 0, 1});
        tbl.push_back('{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1, 1, 1});
        tbl.push_back('{4'd9, 16'hFFFE, 16'h0001, 16'h0001, 0, 1, 0, 0, 1});
        tbl.push_back('{4'd7, 16'h8000, 16'h0003, 16'hF000, 0, 0, 0, 0, 4});
        tbl.push_back('{4'd6, 16'h8000, 16'h0003, 16'h1000, 0, 1, 0, 0, 4});
        tbl.push_back('{4'd5, 16'h0001, 16'h0000, 16'h0001, 0, 1, 0, 0, 1});
        tbl.push_back('{4'd8, 16'd300, 16'd200, 16'hEA60, 0, 0, 0, 0, 17});
        tbl.push_back('{4'd2, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 0, 1});
        tbl.push_back('{4'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 1, 0, 0, 1});
        tbl.push_back('{4'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 0, 1});
        tbl.push_back('{4'd12, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0, 1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst.out", out, 16'd0);
        chk("rst.zero", zero, 16'd0);
        chk("rst.pos", pos, 16'd0);
        chk("rst.flags", {busy, done, carry, ovf}, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run_op($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 60; i++) begin
            rv = model(4'($urandom_range(0, 15)), 16'($urandom),
                       16'($urandom), 1'b1);
            run_op($sformatf("rnd%0d", i), rv);
        end

        // MUL with a stray ADD request during iteration
        @(negedge clk);
        start = 1'b1; op = 4'd8; in0 = 16'd300; in1 = 16'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0; dk = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; op = 4'd0; in0 = 16'd1; in1 = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin nd++; dk = k; end
        end
        chk("ign.ndone", nd, 1);
        chk("ign.cycle", dk, 17);
        chk("ign.out", out, 16'hEA60);

        // async reset in the middle of a MUL
        @(negedge clk);
        start = 1'b1; op = 4'd8; in0 = 16'd300; in1 = 16'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid.busy", busy, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid.out", out, 16'd0);
        chk("mid.zero", zero, 16'd0);
        chk("mid.pos", pos, 16'd0);
        chk("mid.flags", {busy, done, carry, ovf}, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post", model(4'd0, 16'd2, 16'd2, 1'b1));

        run_nm("nm.op8", 4'd8);
        run_nm("nm.op12", 4'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
